// File: rtl/display_mux_ctrl.sv
// display_mux_ctrl: time-multiplexes one hex->7-seg decoder across NUM_DIGITS
// common-anode digits with blanking dead-time and frame-synchronous value updates.
// Optional feature macro: LEADING_ZERO_BLANK_EN (dark leading-zero digits).
module display_mux_ctrl #(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = 2400,
    parameter int DEAD_CYCLES  = 48
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] vals_in,
    input  logic                    vals_valid,
    output logic                    vals_ready,
    output logic [3:0]              num,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frame_tick
);
    localparam int CW = $clog2((DWELL_CYCLES > DEAD_CYCLES ? DWELL_CYCLES : DEAD_CYCLES) + 1);
    localparam int IW = $clog2(NUM_DIGITS);

    typedef enum logic {BLANK, ON} state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [IW-1:0]           idx, idx_n;
    logic                    boundary;
    logic [4*NUM_DIGITS-1:0] active, shadow;
    logic                    pending;
    logic [NUM_DIGITS-1:0]   blank;

    // Slot sequencing: dead-time, then dwell, then advance to the next digit.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        idx_n    = idx;
        boundary = 1'b0;
        if (state == BLANK) begin
            if (cnt == CW'(DEAD_CYCLES - 1)) begin
                state_n = ON;
                cnt_n   = '0;
            end
        end else if (cnt == CW'(DWELL_CYCLES - 1)) begin
            state_n  = BLANK;
            cnt_n    = '0;
            boundary = (idx == IW'(NUM_DIGITS - 1));
            idx_n    = boundary ? '0 : idx + 1'b1;
        end
    end

    // State register for the slot sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end

    // Shadow capture on handshake; active snapshot swaps only at the frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else if (boundary && pending) begin
            active  <= shadow;
            pending <= 1'b0;
        end else if (vals_valid && !pending) begin
            shadow  <= vals_in;
            pending <= 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit above 0 goes dark when it and every higher digit are zero.
    always_comb begin
        logic z;
        blank = '0;
        z     = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            z        = z && (active[4*k +: 4] == 4'h0);
            blank[k] = z;
        end
    end
`else
    assign blank = '0;
`endif

    // Decoder value follows the current slot; the slot's anode lights only in ON.
    always_comb begin
        num    = '0;
        anodes = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IW'(k)) begin
                num = active[4*k +: 4];
                if (state == ON && !blank[k]) anodes[k] = 1'b0;
            end
        end
    end

    assign vals_ready = !pending;
    assign frame_tick = (state == ON) && (idx == '0) && (cnt == '0);

endmodule

// File: tb/tb_display_mux_ctrl.sv
// tb_display_mux_ctrl: table-driven check of display_mux_ctrl (2 digits, dwell 4, dead 1).
module tb_display_mux_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] vals_in = 8'h00;
    logic       vals_valid = 1'b0;
    logic       vals_ready;
    logic [3:0] num;
    logic [1:0] anodes;
    logic       frame_tick;

    int checks = 0;
    int failures = 0;

    localparam logic [1:0] AN1Z =
`ifdef LEADING_ZERO_BLANK_EN
        2'b11;
`else
        2'b01;
`endif

    display_mux_ctrl #(.NUM_DIGITS(2), .DWELL_CYCLES(4), .DEAD_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .vals_in(vals_in), .vals_valid(vals_valid),
        .vals_ready(vals_ready), .num(num), .anodes(anodes), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         len;
        logic       v;
        logic [7:0] d;
        logic [1:0] an;
        logic [3:0] num;
        logic       rdy;
        logic       tick;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int len, logic v, logic [7:0] d, logic [1:0] an,
                                logic [3:0] n, logic rdy, logic tick);
        vec_t r;
        r.len = len; r.v = v; r.d = d; r.an = an; r.num = n; r.rdy = rdy; r.tick = tick;
        return r;
    endfunction

    task automatic cyc(input logic v, input logic [7:0] d);
        vals_valid = v;
        vals_in    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [1:0] an, input logic [3:0] n,
                       input logic rdy, input logic tick);
        checks++;
        if (anodes !== an || num !== n || vals_ready !== rdy || frame_tick !== tick) begin
            failures++;
            $display("FAIL %s: got anodes=%b num=%h ready=%b tick=%b, want anodes=%b num=%h ready=%b tick=%b",
                     name, anodes, num, vals_ready, frame_tick, an, n, rdy, tick);
        end
    endtask

    initial begin
        // edge-by-edge segments after reset release: len, valid, vals, anodes, num, ready, tick
        tbl.push_back(mk(1, 0, 8'hFF, 2'b10, 4'h0, 1, 1));
        tbl.push_back(mk(1, 0, 8'hFF, 2'b10, 4'h0, 1, 0));
        tbl.push_back(mk(1, 1, 8'h3A, 2'b10, 4'h0, 0, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 2'b10, 4'h0, 0, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 2'b11, 4'h0, 0, 0));
        tbl.push_back(mk(4, 0, 8'hFF, AN1Z,  4'h0, 0, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 2'b11, 4'hA, 1, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 2'b10, 4'hA, 1, 1));
        tbl.push_back(mk(1, 1, 8'h12, 2'b10, 4'hA, 0, 0));
        tbl.push_back(mk(2, 1, 8'h34, 2'b10, 4'hA, 0, 0));
        tbl.push_back(mk(1, 1, 8'h34, 2'b11, 4'h3, 0, 0));
        tbl.push_back(mk(4, 1, 8'h34, 2'b01, 4'h3, 0, 0));
        tbl.push_back(mk(1, 1, 8'h34, 2'b11, 4'h2, 1, 0));
        tbl.push_back(mk(1, 1, 8'h34, 2'b10, 4'h2, 0, 1));
        tbl.push_back(mk(3, 0, 8'hFF, 2'b10, 4'h2, 0, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 2'b11, 4'h1, 0, 0));
        tbl.push_back(mk(4, 0, 8'hFF, 2'b01, 4'h1, 0, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 2'b11, 4'h4, 1, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 2'b10, 4'h4, 1, 1));
        tbl.push_back(mk(3, 0, 8'hFF, 2'b10, 4'h4, 1, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 2'b11, 4'h3, 1, 0));
        tbl.push_back(mk(4, 0, 8'hFF, 2'b01, 4'h3, 1, 0));
        tbl.push_back(mk(1, 1, 8'h56, 2'b11, 4'h4, 0, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 2'b10, 4'h4, 0, 1));
        tbl.push_back(mk(3, 0, 8'hFF, 2'b10, 4'h4, 0, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 2'b11, 4'h3, 0, 0));
        tbl.push_back(mk(4, 0, 8'hFF, 2'b01, 4'h3, 0, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 2'b11, 4'h6, 1, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 2'b10, 4'h6, 1, 1));
        tbl.push_back(mk(3, 0, 8'hFF, 2'b10, 4'h6, 1, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 2'b11, 4'h5, 1, 0));
        tbl.push_back(mk(4, 0, 8'hFF, 2'b01, 4'h5, 1, 0));

        reset = 1'b1;
        cyc(0, 8'h00);
        cyc(0, 8'h00);
        chk("reset_state", 2'b11, 4'h0, 1, 0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            for (int j = 0; j < tbl[i].len; j++) begin
                cyc(tbl[i].v, tbl[i].d);
                chk($sformatf("vec%0d_%0d", i, j), tbl[i].an, tbl[i].num, tbl[i].rdy, tbl[i].tick);
            end

        // load on a boundary, then reset during digit 1 with the load still pending
        cyc(1, 8'h78);
        chk("boundary_load", 2'b11, 4'h6, 0, 0);
        for (int i = 0; i < 7; i++) cyc(0, 8'hFF);
        chk("pre_reset_on1", 2'b01, 4'h5, 0, 0);
        reset = 1'b1;
        cyc(0, 8'hFF);
        chk("mid_reset", 2'b11, 4'h0, 1, 0);
        reset = 1'b0;

        // pending lost; then leading-zero patterns 07 and 00
        for (int r = 1; r <= 36; r++) begin
            cyc(r == 12 || r == 22, (r == 12) ? 8'h07 : 8'h00);
            if (r == 1)  chk("post_reset_on0", 2'b10, 4'h0, 1, 1);
            if (r == 10) chk("pending_lost", 2'b11, 4'h0, 1, 0);
            if (r == 12) chk("load07", 2'b10, 4'h0, 0, 0);
            if (r == 21) chk("d0_shows7", 2'b10, 4'h7, 1, 1);
            if (r == 22) chk("load00", 2'b10, 4'h7, 0, 0);
            if (r == 26) chk("d1_zero_slot", AN1Z, 4'h0, 0, 0);
            if (r == 31) chk("d0_shows0", 2'b10, 4'h0, 1, 1);
            if (r == 36) chk("d1_zero_slot2", AN1Z, 4'h0, 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
